// File: rtl/ps2_keyb_event_rx.sv
// PS/2 keyboard front end: input filtering, frame deserialisation with
// parity/stop/timeout checks, prefix and modifier tracking, and a
// first-word-fall-through event FIFO towards the keymap stage.
//
// Frame FSM states:
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data low on a filtered falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the parity bit
//   ST_STOP   | checking the stop bit and odd parity, handing the byte on
module ps2_keyb_event_rx #(
   parameter int DEB_BITS       = 4,
   parameter int FIFO_DEPTH     = 8,
   parameter int TIMEOUT_CYC    = 50000,
   parameter bit REPORT_RELEASE = 1'b1
) (
   input  logic                               sys_clk,
   input  logic                               sys_rst,
   input  logic                               PS2Clk,
   input  logic                               PS2Data,
   output logic                               ev_valid,
   input  logic                               ev_ready,
   output logic [7:0]                         ev_code,
   output logic                               ev_ext,
   output logic                               ev_release,
   output logic [3:0]                         ev_mods,
   output logic                               ev_caps,
   output logic [3:0]                         mods,
   output logic                               caps_lock,
   output logic                               err_parity,
   output logic                               err_frame,
   output logic                               overflow,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level
);

   localparam int LW = $clog2(FIFO_DEPTH + 1);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYC + 1);

   localparam logic [DEB_BITS-1:0] DEB_MAX  = {DEB_BITS{1'b1}};
   localparam logic [TW-1:0]       TMO_LOAD = TW'(TIMEOUT_CYC - 1);
   localparam logic [LW-1:0]       FULL_LVL = LW'(FIFO_DEPTH);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_DATA   = 2'd1;
   localparam logic [1:0] ST_PARITY = 2'd2;
   localparam logic [1:0] ST_STOP   = 2'd3;

   logic [1:0]          clk_s, dat_s;
   logic [DEB_BITS-1:0] clk_cnt, dat_cnt;
   logic                clk_f, dat_f, clk_f_d;
   logic                fe;

   logic [1:0]          state;
   logic [2:0]          bit_cnt;
   logic [7:0]          shreg;
   logic                par_bit;
   logic [TW-1:0]       tmo_cnt;
   logic                byte_vld;
   logic [7:0]          byte_q;

   logic                ext, rel, caps_held;
   logic                is_noise;
   logic                push_vld;
   logic [14:0]         push_data;

   logic [14:0]         mem [FIFO_DEPTH];
   logic [PW-1:0]       wr_ptr, rd_ptr;
   logic [LW-1:0]       level;
   logic                full, pop, push_ok;

   assign fe = clk_f_d & ~clk_f;

   // Synchronise both PS/2 lines and filter them with saturating counters.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         clk_s   <= 2'b11;
         dat_s   <= 2'b11;
         clk_cnt <= DEB_MAX;
         dat_cnt <= DEB_MAX;
         clk_f   <= 1'b1;
         dat_f   <= 1'b1;
         clk_f_d <= 1'b1;
      end else begin
         clk_s <= {clk_s[0], PS2Clk};
         dat_s <= {dat_s[0], PS2Data};

         if (clk_s[1] && clk_cnt != DEB_MAX)
            clk_cnt <= clk_cnt + 1'b1;
         else if (!clk_s[1] && clk_cnt != '0)
            clk_cnt <= clk_cnt - 1'b1;

         if (dat_s[1] && dat_cnt != DEB_MAX)
            dat_cnt <= dat_cnt + 1'b1;
         else if (!dat_s[1] && dat_cnt != '0)
            dat_cnt <= dat_cnt - 1'b1;

         if (clk_cnt == DEB_MAX)
            clk_f <= 1'b1;
         else if (clk_cnt == '0)
            clk_f <= 1'b0;

         if (dat_cnt == DEB_MAX)
            dat_f <= 1'b1;
         else if (dat_cnt == '0)
            dat_f <= 1'b0;

         clk_f_d <= clk_f;
      end
   end

   // Frame FSM with bit timeout; the timer reloads on every filtered falling
   // edge and expires when it reaches zero outside IDLE.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         bit_cnt    <= 3'd0;
         shreg      <= 8'h00;
         par_bit    <= 1'b0;
         tmo_cnt    <= '0;
         byte_vld   <= 1'b0;
         byte_q     <= 8'h00;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;
      end else begin
         byte_vld   <= 1'b0;
         err_parity <= 1'b0;
         err_frame  <= 1'b0;

         if (fe)
            tmo_cnt <= TMO_LOAD;
         else if (state != ST_IDLE && tmo_cnt != '0)
            tmo_cnt <= tmo_cnt - 1'b1;

         if (fe) begin
            case (state)
               ST_IDLE: begin
                  if (!dat_f) begin
                     state   <= ST_DATA;
                     bit_cnt <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shreg   <= {dat_f, shreg[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
                  if (bit_cnt == 3'd7)
                     state <= ST_PARITY;
               end
               ST_PARITY: begin
                  par_bit <= dat_f;
                  state   <= ST_STOP;
               end
               default: begin
                  state <= ST_IDLE;
                  if (!dat_f) begin
                     err_frame <= 1'b1;
                  end else if (^{shreg, par_bit}) begin
                     byte_vld <= 1'b1;
                     byte_q   <= shreg;
                  end else begin
                     err_parity <= 1'b1;
                  end
               end
            endcase
         end else if (state != ST_IDLE && tmo_cnt == '0) begin
            state     <= ST_IDLE;
            err_frame <= 1'b1;
         end
      end
   end

   // Acknowledge/self-test bytes carry no key information.
   assign is_noise = byte_q inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1};

   // Scancode decoder: prefixes, modifiers, Caps Lock latch and event push.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         ext       <= 1'b0;
         rel       <= 1'b0;
         mods      <= 4'b0000;
         caps_lock <= 1'b0;
         caps_held <= 1'b0;
         push_vld  <= 1'b0;
         push_data <= '0;
      end else begin
         push_vld <= 1'b0;
         if (byte_vld) begin
            if (byte_q == 8'hE0) begin
               ext <= 1'b1;
            end else if (byte_q == 8'hF0) begin
               rel <= 1'b1;
            end else begin
               ext <= 1'b0;
               rel <= 1'b0;
               if (is_noise) begin
                  // dropped
               end else if (byte_q == 8'h12) begin
                  mods[0] <= ~rel;
               end else if (byte_q == 8'h59) begin
                  mods[1] <= ~rel;
               end else if (byte_q == 8'h11 && ext) begin
                  mods[2] <= ~rel;
               end else if (byte_q == 8'h14 && !ext) begin
                  mods[3] <= ~rel;
               end else if (byte_q == 8'h58) begin
                  // Typematic repeats arrive as further makes; only the first toggles.
                  if (rel) begin
                     caps_held <= 1'b0;
                  end else if (!caps_held) begin
                     caps_lock <= ~caps_lock;
                     caps_held <= 1'b1;
                  end
               end else if (!rel || REPORT_RELEASE) begin
                  push_vld  <= 1'b1;
                  push_data <= {byte_q, ext, rel, mods, caps_lock};
               end
            end
         end
      end
   end

   assign full     = (level == FULL_LVL);
   assign ev_valid = (level != '0);
   assign pop      = ev_valid & ev_ready;
   assign push_ok  = push_vld & (~full | pop);

   // Event storage; a full FIFO still accepts a push when the head pops.
   always_ff @(posedge sys_clk) begin
      if (push_ok)
         mem[wr_ptr] <= push_data;
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         level    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push_ok && !pop)
            level <= level + 1'b1;
         else if (!push_ok && pop)
            level <= level - 1'b1;
         if (push_vld && full && !pop)
            overflow <= 1'b1;
      end
   end

   assign {ev_code, ev_ext, ev_release, ev_mods, ev_caps} = ev_valid ? mem[rd_ptr] : 15'd0;
   assign fifo_level = level;

endmodule

// File: tb/tb_ps2_keyb_event_rx.sv
// Bench for ps2_keyb_event_rx: drives PS/2 frames, predicts key events with
// a scancode-level model and compares popped events, modifier state,
// error pulses, FIFO behaviour and latency.
module tb_ps2_keyb_event_rx;

   localparam int DEPTH = 4;
   localparam int TMO   = 1000;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic       PS2Clk  = 1'b1;
   logic       PS2Data = 1'b1;
   logic       ev_ready = 1'b0;
   logic       ev_valid;
   logic [7:0] ev_code;
   logic       ev_ext, ev_release, ev_caps;
   logic [3:0] ev_mods, mods;
   logic       caps_lock, err_parity, err_frame, overflow;
   logic [2:0] fifo_level;

   int tests_run = 0;
   int n_fail    = 0;

   always #5 sys_clk = ~sys_clk;

   ps2_keyb_event_rx #(
      .DEB_BITS(4), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYC(TMO), .REPORT_RELEASE(1'b1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .PS2Clk(PS2Clk), .PS2Data(PS2Data),
      .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_code(ev_code), .ev_ext(ev_ext),
      .ev_release(ev_release), .ev_mods(ev_mods), .ev_caps(ev_caps), .mods(mods),
      .caps_lock(caps_lock), .err_parity(err_parity), .err_frame(err_frame),
      .overflow(overflow), .fifo_level(fifo_level)
   );

   // Cycle bookkeeping: filtered-edge timing reference, pulse counters, ev_valid rise latency.
   int cyc = 0, last_fe = 0, rise_lat = -1, n_perr = 0, n_ferr = 0, ferr_cyc = 0;
   bit prev_valid = 1'b0;
   always @(negedge sys_clk) begin
      cyc++;
      if (dut.fe) last_fe = cyc;
      if (ev_valid && !prev_valid) rise_lat = cyc - last_fe;
      prev_valid = ev_valid;
      if (err_parity) n_perr++;
      if (err_frame) begin
         n_ferr++;
         ferr_cyc = cyc;
      end
   end

   // Reference model at scancode level.
   logic [14:0] exp_q[$];
   logic        m_ext, m_rel, m_caps, m_held, m_ovf;
   logic [3:0]  m_mods;

   task automatic model_reset();
      exp_q.delete();
      m_ext = 0; m_rel = 0; m_caps = 0; m_held = 0; m_ovf = 0; m_mods = 4'b0000;
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (b == 8'hE0) m_ext = 1;
      else if (b == 8'hF0) m_rel = 1;
      else begin
         if (b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF, 8'hE1}) begin
         end else if (b == 8'h12) m_mods[0] = !m_rel;
         else if (b == 8'h59) m_mods[1] = !m_rel;
         else if (b == 8'h11 && m_ext) m_mods[2] = !m_rel;
         else if (b == 8'h14 && !m_ext) m_mods[3] = !m_rel;
         else if (b == 8'h58) begin
            if (m_rel) m_held = 0;
            else if (!m_held) begin m_caps = !m_caps; m_held = 1; end
         end else begin
            if (exp_q.size() < DEPTH) exp_q.push_back({b, m_ext, m_rel, m_mods, m_caps});
            else m_ovf = 1;
         end
         m_ext = 0; m_rel = 0;
      end
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge sys_clk);
      #1;
   endtask

   // One PS/2 frame (or its first nbits bits); optional glitches on the clock line.
   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                             input int nbits, input bit glitch);
      logic [10:0] bits;
      bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
      for (int i = 0; i < nbits; i++) begin
         PS2Data = bits[i];
         if (glitch) begin
            wait_cyc(12); PS2Clk = 0; wait_cyc(1); PS2Clk = 1; wait_cyc(8);
         end else wait_cyc(21);
         PS2Clk = 0;
         if (glitch) begin
            wait_cyc(24); PS2Clk = 1; wait_cyc(1); PS2Clk = 0; wait_cyc(5);
         end else wait_cyc(30);
         PS2Clk = 1;
         wait_cyc(10);
      end
      PS2Data = 1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      send_frame(b, 1'b0, 1'b0, 11, 1'b0);
      model_byte(b);
   endtask

   task automatic pop_one(output logic [14:0] obs, output bit got);
      got = 0;
      obs = '0;
      for (int i = 0; i < 50 && !got; i++) begin
         @(negedge sys_clk);
         if (ev_valid) got = 1;
      end
      if (got) begin
         obs = {ev_code, ev_ext, ev_release, ev_mods, ev_caps};
         ev_ready = 1;
         @(negedge sys_clk);
         ev_ready = 0;
      end
   endtask

   task automatic test_reset();
      tests_run++;
      if ({ev_valid, ev_code, ev_ext, ev_release, ev_mods, ev_caps, mods, caps_lock,
           err_parity, err_frame, overflow, fifo_level} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%0b code=%h mods=%b caps=%0b ovf=%0b lvl=%0d, expected all 0",
                  ev_valid, ev_code, mods, caps_lock, overflow, fifo_level);
      end
   endtask

   task automatic test_make_break();
      logic [14:0] obs, e;
      bit got;
      rise_lat = -1;
      send_byte(8'h1C);
      tests_run++;
      if (rise_lat !== 3) begin
         n_fail++; $display("FAIL valid_latency: got %0d cycles after stop edge, expected 3", rise_lat);
      end
      send_byte(8'hF0);
      send_byte(8'h1C);
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL make_break_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
      tests_run++;
      if (mods !== 4'b0000 || ev_valid !== 1'b0) begin
         n_fail++; $display("FAIL make_break_after: got mods=%b valid=%0b, expected 0000/0", mods, ev_valid);
      end
   endtask

   task automatic test_shift();
      logic [14:0] obs, e;
      bit got;
      send_byte(8'h12); send_byte(8'h1C); send_byte(8'hF0); send_byte(8'h12); send_byte(8'h1C);
      tests_run++;
      if (fifo_level !== 3'(exp_q.size())) begin
         n_fail++; $display("FAIL shift_level: got %0d, expected %0d", fifo_level, exp_q.size());
      end
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL shift_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
   endtask

   task automatic test_altgr_caps();
      logic [14:0] obs, e;
      bit got;
      send_byte(8'hE0); send_byte(8'h11); send_byte(8'h15);
      send_byte(8'h58); send_byte(8'h58); send_byte(8'h58);
      send_byte(8'hF0); send_byte(8'h58);
      tests_run++;
      if (caps_lock !== m_caps || mods !== m_mods) begin
         n_fail++; $display("FAIL altgr_caps_state: got caps=%0b mods=%b, expected caps=%0b mods=%b",
                            caps_lock, mods, m_caps, m_mods);
      end
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL altgr_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
      send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h11);
      tests_run++;
      if (mods !== m_mods || ev_valid !== 1'b0) begin
         n_fail++; $display("FAIL altgr_release: got mods=%b valid=%0b, expected mods=%b valid=0",
                            mods, ev_valid, m_mods);
      end
   endtask

   task automatic test_errors();
      int p0, f0;
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h1C, 1'b1, 1'b0, 11, 1'b0); wait_cyc(5);
      tests_run++;
      if (n_perr - p0 != 1 || n_ferr - f0 != 0 || fifo_level !== 3'd0 || ferr_cyc == last_fe + 1) begin
         n_fail++; $display("FAIL parity_error: got perr=%0d ferr=%0d lvl=%0d, expected 1/0/0",
                            n_perr - p0, n_ferr - f0, fifo_level);
      end
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h32, 1'b0, 1'b1, 11, 1'b0); wait_cyc(5);
      tests_run++;
      if (n_perr - p0 != 0 || n_ferr - f0 != 1 || ferr_cyc - last_fe != 1 || fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL stop_error: got perr=%0d ferr=%0d delay=%0d lvl=%0d, expected 0/1/1/0",
                            n_perr - p0, n_ferr - f0, ferr_cyc - last_fe, fifo_level);
      end
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h33, 1'b1, 1'b1, 11, 1'b0); wait_cyc(5);
      tests_run++;
      if (n_perr - p0 != 0 || n_ferr - f0 != 1 || fifo_level !== 3'd0) begin
         n_fail++; $display("FAIL both_errors: got perr=%0d ferr=%0d lvl=%0d, expected 0/1/0",
                            n_perr - p0, n_ferr - f0, fifo_level);
      end
   endtask

   task automatic test_timeout();
      logic [14:0] obs, e;
      bit got;
      int f0, p0;
      f0 = n_ferr; p0 = n_perr;
      send_frame(8'hA5, 1'b0, 1'b0, 5, 1'b0);
      for (int i = 0; i < TMO + 200 && n_ferr == f0; i++) @(negedge sys_clk);
      tests_run++;
      if (n_ferr - f0 != 1 || ferr_cyc - last_fe < TMO || ferr_cyc - last_fe > TMO + 3) begin
         n_fail++; $display("FAIL timeout_pulse: got count=%0d delay=%0d, expected 1 pulse %0d..%0d cycles after last edge",
                            n_ferr - f0, ferr_cyc - last_fe, TMO, TMO + 3);
      end
      wait_cyc(50);
      tests_run++;
      if (n_ferr - f0 != 1 || n_perr != p0) begin
         n_fail++; $display("FAIL timeout_single: got ferr=%0d perr=%0d, expected 1/0", n_ferr - f0, n_perr - p0);
      end
      send_byte(8'h2B);
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL after_timeout_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0]  codes [6];
      logic [14:0] obs, e;
      bit got;
      int nfe;
      codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24;
      codes[3] = 8'h2D; codes[4] = 8'h2C; codes[5] = 8'h35;
      for (int i = 0; i < 4; i++) send_byte(codes[i]);
      tests_run++;
      if (fifo_level !== 3'd4 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL fifo_fill: got lvl=%0d ovf=%0b, expected 4/0", fifo_level, overflow);
      end
      nfe = 0;
      obs = '0;
      fork
         send_frame(codes[4], 1'b0, 1'b0, 11, 1'b0);
         begin
            for (int i = 0; i < 2000 && nfe < 11; i++) begin
               @(negedge sys_clk);
               if (dut.fe) nfe++;
            end
            @(negedge sys_clk);
            @(negedge sys_clk);
            obs = {ev_code, ev_ext, ev_release, ev_mods, ev_caps};
            ev_ready = 1;
            @(negedge sys_clk);
            ev_ready = 0;
         end
      join
      e = exp_q.pop_front();
      model_byte(codes[4]);
      wait_cyc(5);
      tests_run++;
      if (nfe != 11 || obs !== e || fifo_level !== 3'd4 || overflow !== 1'b0) begin
         n_fail++; $display("FAIL full_push_pop: got edges=%0d head=%h lvl=%0d ovf=%0b, expected 11/%h/4/0",
                            nfe, obs, fifo_level, overflow, e);
      end
      send_byte(codes[5]);
      tests_run++;
      if (fifo_level !== 3'd4 || overflow !== m_ovf) begin
         n_fail++; $display("FAIL fifo_overflow: got lvl=%0d ovf=%0b, expected 4/%0b", fifo_level, overflow, m_ovf);
      end
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL fifo_order: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
      tests_run++;
      if (ev_valid !== 1'b0 || overflow !== 1'b1) begin
         n_fail++; $display("FAIL fifo_drained: got valid=%0b ovf=%0b, expected 0/1", ev_valid, overflow);
      end
   endtask

   task automatic test_glitch();
      logic [14:0] obs, e;
      bit got;
      int p0, f0;
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h4B, 1'b0, 1'b0, 11, 1'b1);
      model_byte(8'h4B);
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL glitch_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
      tests_run++;
      if (n_perr != p0 || n_ferr != f0 || ev_valid !== 1'b0) begin
         n_fail++; $display("FAIL glitch_errors: got perr=%0d ferr=%0d valid=%0b, expected 0/0/0",
                            n_perr - p0, n_ferr - f0, ev_valid);
      end
   endtask

   task automatic test_reset_mid_frame();
      logic [14:0] obs, e;
      bit got;
      int p0, f0;
      send_byte(8'h12); send_byte(8'h1C);
      tests_run++;
      if (mods !== m_mods || fifo_level !== 3'd1) begin
         n_fail++; $display("FAIL pre_reset_state: got mods=%b lvl=%0d, expected %b/1", mods, fifo_level, m_mods);
      end
      p0 = n_perr; f0 = n_ferr;
      send_frame(8'h4D, 1'b0, 1'b0, 5, 1'b0);
      sys_rst = 1; wait_cyc(3); sys_rst = 0;
      model_reset();
      tests_run++;
      if ({ev_valid, fifo_level, mods, caps_lock, overflow} !== '0) begin
         n_fail++; $display("FAIL reset_mid_frame: got valid=%0b lvl=%0d mods=%b caps=%0b ovf=%0b, expected all 0",
                            ev_valid, fifo_level, mods, caps_lock, overflow);
      end
      wait_cyc(TMO + 200);
      tests_run++;
      if (n_perr != p0 || n_ferr != f0) begin
         n_fail++; $display("FAIL reset_no_error: got perr=%0d ferr=%0d, expected 0/0", n_perr - p0, n_ferr - f0);
      end
      send_byte(8'h1B);
      while (exp_q.size() != 0) begin
         pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
         if (!got || obs !== e) begin
            n_fail++; $display("FAIL post_reset_event: got %h (valid %0b), expected %h", obs, got, e);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0]  specials [10];
      logic [7:0]  b;
      logic [14:0] obs, e;
      bit got;
      specials[0] = 8'hE0; specials[1] = 8'hF0; specials[2] = 8'h12; specials[3] = 8'h59;
      specials[4] = 8'h11; specials[5] = 8'h14; specials[6] = 8'h58; specials[7] = 8'hFA;
      specials[8] = 8'hE1; specials[9] = 8'h00;
      for (int n = 0; n < 24; n++) begin
         if ($urandom_range(0, 1) == 1) b = specials[$urandom_range(0, 9)];
         else b = 8'($urandom_range(0, 255));
         send_byte(b);
         tests_run++;
         if (mods !== m_mods || caps_lock !== m_caps) begin
            n_fail++; $display("FAIL random_state byte %h: got mods=%b caps=%0b, expected mods=%b caps=%0b",
                               b, mods, caps_lock, m_mods, m_caps);
         end
         while (exp_q.size() != 0) begin
            pop_one(obs, got); e = exp_q.pop_front(); tests_run++;
            if (!got || obs !== e) begin
               n_fail++; $display("FAIL random_event byte %h: got %h (valid %0b), expected %h", b, obs, got, e);
            end
         end
      end
      tests_run++;
      if (ev_valid !== 1'b0 || overflow !== m_ovf) begin
         n_fail++; $display("FAIL random_end: got valid=%0b ovf=%0b, expected 0/%0b", ev_valid, overflow, m_ovf);
      end
   endtask

   initial begin
      model_reset();
      wait_cyc(5);
      sys_rst = 0;
      wait_cyc(3);
      test_reset();
      test_make_break();
      test_shift();
      test_altgr_caps();
      test_errors();
      test_timeout();
      test_back_to_back();
      test_glitch();
      test_reset_mid_frame();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, n_fail);
      $finish;
   end

   initial begin
      #950000;
      $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/ps2_keyb_event_rx.md
Name: ps2_keyb_event_rx

Overview:
- Parametrised next-generation PS/2 keyboard front end, fully synchronous to sys_clk. No clocking on the filtered PS/2 clock.
- Filters PS2Clk and PS2Data, deserialises 11-bit frames and checks parity, stop bit and bit timeout.
- Tracks prefixes (E0/F0), modifiers and Caps Lock, then queues key events in a FIFO with valid/ready output.
- Sits between the PS/2 pins and the ASCII/keymap stage; that stage pops events at its own pace.

Parameters:
- DEB_BITS, 4: width of each saturating debounce counter; a line must hold for 2^DEB_BITS-1 cycles to change.
- FIFO_DEPTH, 8: event FIFO depth; power of 2, at least 2.
- TIMEOUT_CYC, 50000: sys_clk cycles without a filtered falling edge before a partial frame is abandoned.
- REPORT_RELEASE, 1: 1 queues break events for non-modifier keys; 0 queues make events only.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- PS2Clk  in  1  raw PS/2 clock, asynchronous.
- PS2Data  in  1  raw PS/2 data, asynchronous.
- ev_valid  out  1  FIFO not empty.
- ev_ready  in  1  consumer accepts the head event.
- ev_code  out  8  scancode of the head event.
- ev_ext  out  1  head event carried an E0 prefix.
- ev_release  out  1  head event is a break.
- ev_mods  out  4  {LCtrl, AltGr, RShift, LShift}, captured when the event was queued.
- ev_caps  out  1  Caps Lock state, captured when the event was queued.
- mods  out  4  live modifier state.
- caps_lock  out  1  live Caps Lock state.
- err_parity  out  1  one-cycle pulse on a parity error.
- err_frame  out  1  one-cycle pulse on a stop-bit error or timeout.
- overflow  out  1  sticky; an event was dropped because the FIFO was full.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  number of queued events.

Behaviour:
- Reset:
  - All outputs 0; FIFO empty.
  - Debounce counters at all-ones; filtered clock and data = 1.
  - Frame FSM in IDLE; E0/F0 flags cleared; caps_held = 0.
  - Reset mid-frame discards the partial byte and produces no error pulse.
- Input sampling: each raw input passes a 2-flop synchroniser, then its debounce counter.
  - Counter increments when the line is 1 and decrements when 0, saturating at both ends.
  - Filtered output becomes 1 at all-ones and 0 at zero; otherwise it holds.
- Edge detect: fe = previous filtered clock & ~current filtered clock. Filtered data is sampled on the fe cycle.
- Frame FSM (advances only on fe):
  - IDLE -> DATA when data = 0 (start bit); data = 1 stays in IDLE.
  - DATA: 8 bits, LSB first, then -> PARITY.
  - PARITY -> STOP; parity bit stored.
  - STOP -> IDLE; the byte is accepted if the stop bit = 1 and the 9 bits {data, parity} have odd parity.
  - Bad parity: err_parity pulses and the byte is dropped.
  - Stop bit = 0: err_frame pulses and the byte is dropped. If both are bad, only err_frame pulses.
- Timeout: counter clears on every fe and counts in any state other than IDLE. On reaching TIMEOUT_CYC: -> IDLE, err_frame pulses, byte dropped.
- Decoder (on the cycle after the STOP fe with an accepted byte):
  - E0 sets ext. F0 sets rel.
  - FA, AA, EE, FE, 00, FF, E1 are dropped and clear ext and rel.
  - Modifier keys (LShift 12, RShift 59, AltGr E0+11, LCtrl 14 without E0): update mods (make = 1, break = 0) and are never queued.
  - Caps Lock 58:
    - make with caps_held = 0 toggles caps_lock and sets caps_held;
    - typematic makes do not toggle;
    - break clears caps_held;
    - the Caps Lock key itself is never queued.
  - Any other byte: push {code, ext, rel, mods, caps_lock} to the FIFO.
    - A break is pushed only when REPORT_RELEASE = 1.
    - ev_mods/ev_caps reflect modifier state before this byte is applied.
  - ext and rel clear after every non-prefix byte.
- FIFO (first-word-fall-through):
  - A pop occurs when ev_valid & ev_ready.
  - Push while full with no pop: event dropped, overflow set (cleared only by reset).
  - Push while full with a pop in the same cycle: accepted; level is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - ev_* outputs are don't-care while ev_valid = 0.
- Latency: with an empty FIFO, ev_valid rises exactly 3 sys_clk cycles after the fe cycle that samples a good stop bit. That same fe cycle is also the reference point for the error pulses:
  - err_parity / err_frame assert on the next cycle;
  - a timeout pulse asserts the cycle after the count is reached.

Test Plan:
- Frame 1C (A) then F0 1C, REPORT_RELEASE = 1, ev_ready = 1 -> two events: {1C, ext 0, rel 0} and {1C, ext 0, rel 1}; mods = 0; ev_valid rises 3 cycles after the stop fe.
- Make 12, make 1C, break 12 (F0 12), make 1C -> events: 1C with ev_mods = 0001, then 1C with ev_mods = 0000; the shift bytes are never queued.
- E0 11, make 15, then 58 sent three times and F0 58 -> 15 event with ev_mods = 0100; caps_lock toggles once to 1, not three times.
- Frame with a bad parity bit -> err_parity pulses once, no event. Frame with stop bit 0 -> err_frame pulses once. Clock stopped after 4 data bits with TIMEOUT_CYC = 1000 -> err_frame pulses at cycle 1000; the next good frame decodes correctly.
- FIFO_DEPTH = 4, ev_ready = 0, six makes -> fifo_level = 4, overflow = 1, the first four codes pop in order. Also: full FIFO with a push and pop in the same cycle -> no overflow, level stays 4.
- 1-cycle glitches on PS2Clk (width < 2^DEB_BITS-1) during a frame -> no extra fe, correct byte. sys_rst asserted mid-frame -> FIFO empty, mods = 0, no error pulse.
